// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified memory port.
// Also used by the datapath and memory models.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch / data arbiter in front of one single-port, variable-latency memory.
// Holds one fetched instruction and the last load result.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_take,
  input  logic              if_flush,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t state;
  grant_t     last_grant;
  logic       drop;

  logic cand_d;
  logic cand_f;
  logic pick_d;

  // d_req in the d_done cycle still belongs to the finished access
  assign cand_d = d_req & ~d_done;
  assign cand_f = ~instr_valid & ~if_flush;
  assign pick_d = cand_d &
                  (~cand_f | (last_grant == GNT_FETCH));

  assign stall_fetch = ~instr_valid;
  assign stall_mem   = d_req & ~d_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GNT_FETCH;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr_o     <= '0;
      d_rdata     <= '0;
      d_done      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      d_done <= 1'b0;
      if (if_take | if_flush)
        instr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (cand_f) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            drop     <= 1'b0;
          end
        end
        DATA: begin
          if (mem_ready) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            d_rdata    <= mem_rdata;
            d_done     <= 1'b1;
            last_grant <= GNT_DATA;
          end
        end
        FETCH: begin
          // a redirected fetch still finishes on the bus, result discarded
          if (mem_ready) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            last_grant <= GNT_FETCH;
            drop       <= 1'b0;
            if (!(drop | if_flush)) begin
              instr_o     <= mem_rdata;
              instr_valid <= 1'b1;
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port, variable-latency memory between the pipeline's instruction-fetch stage and its data-memory stage, so the core can run from a unified memory.
- Sequences every memory access through a small state machine.
- Buffers one fetched instruction and returns load data.
- Drives the fetch and memory stall requests consumed by the hazard unit.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data/instruction width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_addr  in  ADDR_W  fetch address (pc).
- if_take  in  1  pulse: fetch stage consumed instr_o (pc advances).
- if_flush  in  1  pulse: branch redirect; discard buffered/in-flight fetch.
- instr_o  out  DATA_W  buffered instruction.
- instr_valid  out  1  instr_o valid; held until if_take or if_flush.
- d_req  in  1  data access pending (memwritem | memtoregm); held until d_done.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address (aluoutm).
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, held until next data completion.
- d_done  out  1  one-cycle pulse: data access finished.
- stall_fetch  out  1  = ~instr_valid.
- stall_mem  out  1  = d_req & ~d_done, freezes whole pipeline.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
- mem_ready  in  1  completes the access in the cycle mem_req & mem_ready.

## Operation
- States:
  - IDLE: mem_req = 0.
  - DATA: data access in flight.
  - FETCH: fetch in flight.
- IDLE grant:
  - Candidates are data (d_req & ~d_done) and fetch (~instr_valid & ~if_flush).
  - If both are pending, grant the one not granted last. last_grant resets to FETCH, so data wins first.
  - On a grant, latch the address, we and wdata into request registers.
- DATA:
  - Drive mem_req = 1 with the latched request.
  - On mem_ready: capture mem_rdata into d_rdata (stores too), pulse d_done next cycle, go to IDLE, set last_grant = DATA.
- FETCH:
  - Drive mem_req = 1, mem_we = 0, with the latched if_addr.
  - On mem_ready: load instr_o, set instr_valid, go to IDLE, set last_grant = FETCH. If the drop flag is set, do neither load nor valid; clear the flag instead.
- if_flush:
  - Clears instr_valid immediately at the edge.
  - In FETCH, sets the drop flag. The access still completes on the memory bus and is never aborted.
- if_take clears instr_valid. if_take and if_flush in the same cycle: the flush effect applies.
- In the cycle d_done = 1, d_req belongs to the finished access. It is not a new candidate.
- No new fetch is issued while instr_valid = 1 (one-entry buffer).
- Memory outputs are registered state only. None depends combinationally on d_req or if_addr.

## Timing
- Reset values:
  - state = IDLE, last_grant = FETCH, drop = 0.
  - instr_valid = 0, instr_o = 0, d_rdata = 0, d_done = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - stall_fetch = 1, stall_mem = d_req.
- rst mid-access abandons the transaction: state is IDLE and mem_req = 0 next cycle.
- Latency from request seen in IDLE:
  - grant edge, then N ≥ 1 cycles in DATA/FETCH until mem_ready, then the result is registered.
  - Zero-wait memory (mem_ready tied 1): d_done or instr_valid rises 2 cycles after the request is seen.
- The memory must hold mem_rdata valid only in the mem_ready cycle. The arbiter holds mem_req and address stable until then.
- Back-to-back: a different requester can be granted in the same IDLE cycle that d_done is high.

## Structure
- Shared package holds:
  - arb_state_t enum {IDLE, DATA, FETCH}.
  - grant_t {GNT_FETCH, GNT_DATA}.
  - Default ADDR_W / DATA_W constants, also used by datapath and memory models.
- Single flat module. No sub-module is natural; the arbiter plus request/response registers fit in ~200 lines.

## Test plan
- Reset, then idle memory with zero-wait mem_ready=1, if_addr=0x0, no d_req → mem_req/mem_addr=0x0 one cycle after reset release, instr_valid=1 two cycles later with instr_o = mem_rdata.
- Both pending at the first IDLE (d_req=1, d_addr=0x100, d_we=0, instr_valid=0) → DATA granted first. d_done pulses with d_rdata=0xDEADBEEF, then FETCH is granted next; stall_mem is high until d_done.
- Store d_we=1, d_addr=0x40, d_wdata=0x12345678 with mem_ready delayed 3 cycles → mem_we=1 and the address/data are stable all 4 request cycles, d_done is a single pulse, stall_mem drops in that cycle.
- if_flush while in FETCH with the ready 2 cycles away → completion is ignored, instr_valid stays 0, and a new fetch of the new if_addr=0x80 is issued from IDLE.
- rst asserted during DATA with mem_ready never returned → next cycle mem_req=0, state IDLE, d_done=0, instr_valid=0.
- Continuous d_req alternating with fetch demand for 20 accesses → grants strictly alternate, no starvation, no d_done without a preceding mem_req & mem_ready.
